instr_encoder_loader: RTL and testbench

- Instruction encoder and instruction-memory loader for the single-cycle MIPS subset: add, sub, and, or, addi, andi, ori, lw, sw, beq, bne, j.
- Accepts one mnemonic plus operand fields per handshake and packs them into a 32-bit MIPS word.
- Writes words to consecutive instruction-memory addresses, producing exactly the Op/Func encodings the control unit decodes.
- Sits between the testbench/boot source and instruction memory.

---
 rtl/instr_encoder_loader_if.sv | 34 +++
 rtl/instr_encoder_loader.sv | 194 +++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Request/instruction-memory bundle for instr_encoder_loader.
//   master : boot source / testbench side (drives the request, observes writes)
//   slave  : encoder side (accepts requests, drives the memory write port)
// Signals: In_valid/In_ready handshake, Mnem/Rs/Rt/Rd/Imm/Target operand fields,
// Flush pad request, Imem_we/Imem_addr/Imem_wdata write port, Count/Full/Err status.
interface instr_encoder_loader_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              In_valid;
    logic              In_ready;
    logic [3:0]        Mnem;
    logic [4:0]        Rs;
    logic [4:0]        Rt;
    logic [4:0]        Rd;
    logic [15:0]       Imm;
    logic [25:0]       Target;
    logic              Flush;
    logic              Imem_we;
    logic [ADDR_W-1:0] Imem_addr;
    logic [31:0]       Imem_wdata;
    logic [ADDR_W:0]   Count;
    logic              Full;
    logic              Err;

    modport master (
        output In_valid, Mnem, Rs, Rt, Rd, Imm, Target, Flush,
        input  In_ready, Imem_we, Imem_addr, Imem_wdata, Count, Full, Err
    );

    modport slave (
        input  In_valid, Mnem, Rs, Rt, Rd, Imm, Target, Flush,
        output In_ready, Imem_we, Imem_addr, Imem_wdata, Count, Full, Err
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Instruction encoder + instruction-memory loader for the MIPS subset
// add/sub/and/or/addi/andi/ori/lw/sw/beq/bne/j. One request per handshake is
// packed into a 32-bit word and written to the next instruction-memory address.
// Ports: Clk, Clrn (synchronous active-low reset), bus (instr_encoder_loader_if.slave).
// Optional macro NOP_PAD_EN: Flush in IDLE fills the rest of memory with NOPs.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic                   Clk,
    input  logic                   Clrn,
    instr_encoder_loader_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENCODE = 3'd1,
        S_WRITE  = 3'd2,
        S_FULL   = 3'd3
`ifdef NOP_PAD_EN
        , S_PAD  = 3'd4
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                capture;
    logic [3:0]          mnem_q;
    logic [4:0]          rs_q, rt_q, rd_q;
    logic [15:0]         imm_q;
    logic [25:0]         target_q;
    logic [31:0]         enc_word;
    logic                enc_legal;

    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full_q, full_d;
    logic                err_q, err_d;

    // State register
    always_ff @(posedge Clk) begin
        if (!Clrn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Request field capture on acceptance
    always_ff @(posedge Clk) begin
        if (capture) begin
            mnem_q   <= bus.Mnem;
            rs_q     <= bus.Rs;
            rt_q     <= bus.Rt;
            rd_q     <= bus.Rd;
            imm_q    <= bus.Imm;
            target_q <= bus.Target;
        end
    end

    // Pack the captured fields into a MIPS word
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (mnem_q)
            4'd0:    enc_word = {OP_RTYPE, rs_q, rt_q, rd_q, 5'd0, FN_ADD};
            4'd1:    enc_word = {OP_RTYPE, rs_q, rt_q, rd_q, 5'd0, FN_SUB};
            4'd2:    enc_word = {OP_RTYPE, rs_q, rt_q, rd_q, 5'd0, FN_AND};
            4'd3:    enc_word = {OP_RTYPE, rs_q, rt_q, rd_q, 5'd0, FN_OR};
            4'd4:    enc_word = {OP_ADDI, rs_q, rt_q, imm_q};
            4'd5:    enc_word = {OP_ANDI, rs_q, rt_q, imm_q};
            4'd6:    enc_word = {OP_ORI,  rs_q, rt_q, imm_q};
            4'd7:    enc_word = {OP_LW,   rs_q, rt_q, imm_q};
            4'd8:    enc_word = {OP_SW,   rs_q, rt_q, imm_q};
            4'd9:    enc_word = {OP_BEQ,  rs_q, rt_q, imm_q};
            4'd10:   enc_word = {OP_BNE,  rs_q, rt_q, imm_q};
            4'd11:   enc_word = {OP_J,    target_q};
            default: enc_legal = 1'b0;
        endcase
    end

    // Next state and next register values; Err is decoded from the incoming
    // Mnem at acceptance so its pulse lines up with the ENCODE cycle.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
`ifdef NOP_PAD_EN
                if (bus.Flush) begin
                    state_d = S_PAD;
                    we_d    = 1'b1;
                    wdata_d = '0;
                end else
`endif
                if (bus.In_valid) begin
                    capture = 1'b1;
                    state_d = S_ENCODE;
                    err_d   = (bus.Mnem > 4'd11);
                end
            end
            S_ENCODE: begin
                if (enc_legal) begin
                    state_d = S_WRITE;
                    we_d    = 1'b1;
                    wdata_d = enc_word;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                count_d = count_q + CNT_W'(1);
                if (addr_q == LAST_ADDR) begin
                    state_d = S_FULL;
                    full_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
`ifdef NOP_PAD_EN
            S_PAD: begin
                count_d = count_q + CNT_W'(1);
                if (addr_q == LAST_ADDR) begin
                    state_d = S_FULL;
                    full_d  = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
`endif
            S_FULL: begin
                state_d = S_FULL;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    // Ready is a pure IDLE decode, forced low while reset is asserted
    assign bus.In_ready   = Clrn && (state_q == S_IDLE);
    assign bus.Imem_we    = we_q;
    assign bus.Imem_addr  = addr_q;
    assign bus.Imem_wdata = wdata_q;
    assign bus.Count      = count_q;
    assign bus.Full       = full_q;
    assign bus.Err        = err_q;

`ifndef NOP_PAD_EN
    logic unused_flush;
    assign unused_flush = bus.Flush;
`endif
endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 8;

    logic Clk  = 1'b0;
    logic Clrn = 1'b0;

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();
    instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (.Clk(Clk), .Clrn(Clrn), .bus(bus));

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int err_pulses = 0;
    int model_count = 0;
    int unsigned exp_addr[$];
    logic [31:0] exp_data[$];
    int unsigned got_addr[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];

    always @(posedge Clk) cyc++;

    // Write/err monitor sampled mid-cycle
    always @(negedge Clk) begin
        if (Clrn === 1'b1 && bus.Imem_we === 1'b1) begin
            got_addr.push_back(int'(bus.Imem_addr));
            got_data.push_back(bus.Imem_wdata);
            got_cyc.push_back(cyc);
        end
        if (Clrn === 1'b1 && bus.Err === 1'b1) err_pulses++;
    end

    // Reference encoder built from opcode/funct tables
    function automatic logic [31:0] ref_word(input int unsigned m, input int unsigned rs,
                                             input int unsigned rt, input int unsigned rd,
                                             input int unsigned imm, input int unsigned tgt,
                                             output bit legal);
        int unsigned func_tab[4] = '{32, 34, 36, 37};
        int unsigned op_tab[7]   = '{8, 12, 13, 35, 43, 4, 5};
        int unsigned w;
        legal = 1'b1;
        w = 0;
        if (m < 4)       w = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + func_tab[m];
        else if (m < 11) w = op_tab[m - 4] * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
        else if (m == 11) w = 2 * (1 << 26) + tgt;
        else legal = 1'b0;
        return w;
    endfunction

    task automatic clear_q();
        exp_addr.delete(); exp_data.delete();
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        err_pulses = 0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Clrn = 1'b0; bus.In_valid = 1'b0; bus.Flush = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Clrn = 1'b1;
        model_count = 0;
        clear_q();
    endtask

    // Waits (bounded) for ready, presents one request for one edge, updates the model
    task automatic send_req(input int unsigned m, input int unsigned rs, input int unsigned rt,
                            input int unsigned rd, input int unsigned imm, input int unsigned tgt,
                            input bit fl);
        int  waited = 0;
        bit  legal;
        logic [31:0] w;
        @(negedge Clk);
        while (bus.In_ready !== 1'b1 && waited < 20) begin
            @(negedge Clk);
            waited++;
        end
        if (waited >= 20) begin
            n_checks++;
            $display("FAIL ready_timeout: In_ready=%b after %0d cycles, required 1", bus.In_ready, waited);
        end
        bus.Mnem = 4'(m); bus.Rs = 5'(rs); bus.Rt = 5'(rt); bus.Rd = 5'(rd);
        bus.Imm = 16'(imm); bus.Target = 26'(tgt); bus.Flush = fl; bus.In_valid = 1'b1;
        @(posedge Clk);
        #1;
        bus.In_valid = 1'b0;
        bus.Flush = 1'b0;
        w = ref_word(m, rs, rt, rd, imm, tgt, legal);
        if (legal && model_count < int'(DEPTH)) begin
            exp_addr.push_back(model_count);
            exp_data.push_back(w);
            model_count++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        n_checks++; if (bus.Imem_we !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.Imem_we); else n_pass++;
        n_checks++; if (bus.Imem_addr !== '0) $display("FAIL reset_addr: got %0h want 0", bus.Imem_addr); else n_pass++;
        n_checks++; if (bus.Imem_wdata !== 32'h0) $display("FAIL reset_wdata: got %08h want 0", bus.Imem_wdata); else n_pass++;
        n_checks++; if (bus.Count !== '0) $display("FAIL reset_count: got %0d want 0", bus.Count); else n_pass++;
        n_checks++; if (bus.Full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.Full); else n_pass++;
        n_checks++; if (bus.Err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.Err); else n_pass++;
        n_checks++; if (bus.In_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.In_ready); else n_pass++;
        Clrn = 1'b1;
        model_count = 0;
        clear_q();
    endtask

    task automatic test_add_latency();
        @(negedge Clk);
        n_checks++; if (bus.In_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", bus.In_ready); else n_pass++;
        bus.Mnem = 4'd0; bus.Rs = 5'd1; bus.Rt = 5'd2; bus.Rd = 5'd3; bus.In_valid = 1'b1;
        @(posedge Clk);
        #1 bus.In_valid = 1'b0;
        @(negedge Clk);
        n_checks++; if (bus.Imem_we !== 1'b0 || bus.In_ready !== 1'b0)
            $display("FAIL encode_cycle: we=%b ready=%b want 0/0", bus.Imem_we, bus.In_ready); else n_pass++;
        @(negedge Clk);
        n_checks++; if (bus.Imem_we !== 1'b1) $display("FAIL add_we: got %b want 1", bus.Imem_we); else n_pass++;
        n_checks++; if (bus.Imem_addr !== 3'd0) $display("FAIL add_addr: got %0d want 0", bus.Imem_addr); else n_pass++;
        n_checks++; if (bus.Imem_wdata !== 32'h00221820) $display("FAIL add_word: got %08h want 00221820", bus.Imem_wdata); else n_pass++;
        @(negedge Clk);
        n_checks++; if (bus.Imem_we !== 1'b0 || bus.Count !== 4'd1)
            $display("FAIL add_after: we=%b count=%0d want 0/1", bus.Imem_we, bus.Count); else n_pass++;
        n_checks++; if (bus.Imem_wdata !== 32'h00221820) $display("FAIL wdata_hold: got %08h want 00221820", bus.Imem_wdata); else n_pass++;
        model_count = 1;
    endtask

    task automatic test_sequence();
        do_reset();
        send_req(7, 0, 4, 0, 16'h0008, 0, 1'b0);
        send_req(9, 4, 5, 0, 16'hFFFF, 0, 1'b0);
        send_req(11, 0, 0, 0, 0, 26'h0000010, 1'b0);
        repeat (4) @(negedge Clk);
        n_checks++; if (got_addr.size() != 3) $display("FAIL seq_writes: got %0d writes want 3", got_addr.size()); else n_pass++;
        if (got_addr.size() == 3) begin
            n_checks++; if (got_addr[0] != 0 || got_data[0] !== 32'h8C040008)
                $display("FAIL seq_lw: addr %0d data %08h want 0/8C040008", got_addr[0], got_data[0]); else n_pass++;
            n_checks++; if (got_addr[1] != 1 || got_data[1] !== 32'h1085FFFF)
                $display("FAIL seq_beq: addr %0d data %08h want 1/1085FFFF", got_addr[1], got_data[1]); else n_pass++;
            n_checks++; if (got_addr[2] != 2 || got_data[2] !== 32'h08000010)
                $display("FAIL seq_j: addr %0d data %08h want 2/08000010", got_addr[2], got_data[2]); else n_pass++;
        end
    endtask

    task automatic test_illegal();
        logic [ADDR_W:0] c0;
        clear_q();
        c0 = bus.Count;
        send_req(13, 3, 3, 3, 16'h1234, 0, 1'b0);
        repeat (4) @(negedge Clk);
        n_checks++; if (err_pulses != 1) $display("FAIL illegal_err: got %0d pulse cycles want 1", err_pulses); else n_pass++;
        n_checks++; if (got_addr.size() != 0) $display("FAIL illegal_nowrite: got %0d writes want 0", got_addr.size()); else n_pass++;
        n_checks++; if (bus.Count !== c0) $display("FAIL illegal_count: got %0d want %0d", bus.Count, c0); else n_pass++;
        send_req(1, 6, 7, 8, 0, 0, 1'b0);
        repeat (4) @(negedge Clk);
        n_checks++; if (got_addr.size() != 1 || got_addr[0] != int'(c0))
            $display("FAIL illegal_next_addr: writes %0d addr %0d want 1/%0d", got_addr.size(),
                     (got_addr.size() > 0) ? got_addr[0] : 999, c0); else n_pass++;
    endtask

    task automatic test_random();
        int iter = 0;
        int illegal_n = 0;
        int nw;
        bit fl;
        clear_q();
        while (model_count < int'(DEPTH) && iter < 60) begin
            int unsigned m = $urandom_range(0, 15);
            if (m > 11) illegal_n++;
`ifndef NOP_PAD_EN
            fl = 1'($urandom_range(0, 1));
`else
            fl = 1'b0;
`endif
            send_req(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 65535), $urandom & 32'h03FFFFFF, fl);
            iter++;
        end
        repeat (4) @(negedge Clk);
        n_checks++; if (got_addr.size() != exp_addr.size())
            $display("FAIL rand_writes: got %0d want %0d", got_addr.size(), exp_addr.size()); else n_pass++;
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            n_checks++;
            if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i])
                $display("FAIL rand_word[%0d]: addr %0d data %08h want %0d/%08h", i, got_addr[i], got_data[i],
                         exp_addr[i], exp_data[i]);
            else n_pass++;
        end
        n_checks++; if (err_pulses != illegal_n) $display("FAIL rand_err: got %0d want %0d", err_pulses, illegal_n); else n_pass++;
        n_checks++; if (bus.Full !== 1'b1 || bus.Count !== 4'(DEPTH) || bus.In_ready !== 1'b0)
            $display("FAIL full_state: full=%b count=%0d ready=%b want 1/%0d/0", bus.Full, bus.Count, bus.In_ready, DEPTH);
        else n_pass++;
        nw = got_addr.size();
        bus.Mnem = 4'd0; bus.In_valid = 1'b1; bus.Flush = 1'b1;
        repeat (6) @(negedge Clk);
        bus.In_valid = 1'b0; bus.Flush = 1'b0;
        repeat (2) @(negedge Clk);
        n_checks++; if (got_addr.size() != nw || bus.Count !== 4'(DEPTH) || bus.Full !== 1'b1)
            $display("FAIL full_ignore: writes %0d count %0d full %b want %0d/%0d/1", got_addr.size(), bus.Count, bus.Full, nw, DEPTH);
        else n_pass++;
    endtask

    task automatic test_reset_mid_encode();
        do_reset();
        @(negedge Clk);
        bus.Mnem = 4'd6; bus.Rs = 5'd2; bus.Rt = 5'd9; bus.Imm = 16'hBEEF; bus.In_valid = 1'b1;
        @(posedge Clk);
        #1 bus.In_valid = 1'b0;
        @(negedge Clk);
        Clrn = 1'b0;
        @(negedge Clk);
        Clrn = 1'b1;
        repeat (3) @(negedge Clk);
        n_checks++; if (got_addr.size() != 0 || bus.Count !== '0)
            $display("FAIL abort_nowrite: writes %0d count %0d want 0/0", got_addr.size(), bus.Count); else n_pass++;
        model_count = 0;
        send_req(2, 10, 11, 12, 0, 0, 1'b0);
        repeat (4) @(negedge Clk);
        n_checks++; if (got_addr.size() != 1 || got_addr[0] != 0 || got_data[0] !== exp_data[0])
            $display("FAIL abort_next: writes %0d addr %0d data %08h want 1/0/%08h", got_addr.size(),
                     (got_addr.size() > 0) ? got_addr[0] : 999, (got_data.size() > 0) ? got_data[0] : 32'hX, exp_data[0]);
        else n_pass++;
    endtask

`ifdef NOP_PAD_EN
    task automatic test_pad();
        int waited = 0;
        do_reset();
        send_req(0, 1, 2, 3, 0, 0, 1'b0);
        send_req(4, 1, 1, 0, 16'h0005, 0, 1'b0);
        @(negedge Clk);
        while (bus.In_ready !== 1'b1 && waited < 20) begin @(negedge Clk); waited++; end
        bus.Flush = 1'b1; bus.In_valid = 1'b1; bus.Mnem = 4'd0;
        @(posedge Clk);
        #1 bus.Flush = 1'b0; bus.In_valid = 1'b0;
        repeat (12) @(negedge Clk);
        n_checks++; if (got_addr.size() != 8) $display("FAIL pad_writes: got %0d want 8", got_addr.size()); else n_pass++;
        for (int i = 2; i < 8 && i < got_addr.size(); i++) begin
            n_checks++;
            if (got_addr[i] != i || got_data[i] !== 32'h0 || (i > 2 && got_cyc[i] != got_cyc[i-1] + 1))
                $display("FAIL pad_word[%0d]: addr %0d data %08h cyc %0d want %0d/0/consecutive", i, got_addr[i],
                         got_data[i], got_cyc[i], i);
            else n_pass++;
        end
        n_checks++; if (bus.Full !== 1'b1 || bus.Count !== 4'd8)
            $display("FAIL pad_full: full=%b count=%0d want 1/8", bus.Full, bus.Count); else n_pass++;
    endtask
`endif

    initial begin
        bus.In_valid = 1'b0; bus.Flush = 1'b0; bus.Mnem = '0; bus.Rs = '0; bus.Rt = '0;
        bus.Rd = '0; bus.Imm = '0; bus.Target = '0;
        test_reset();
        test_add_latency();
        test_sequence();
        test_illegal();
        test_random();
        test_reset_mid_encode();
`ifdef NOP_PAD_EN
        test_pad();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
